// File: rtl/decap_rule_pkg.sv
// decap_rule_pkg: shared types and constants for the decap rule table.
//   - AXI response codes, write/read FSM encodings, register selector.
//   - Register map offsets and CTRL field positions.
//   - Helpers to pack/unpack a rule CTRL word and to decode a register address.
// Optional feature: DECAP_RULE_MISS_CNT_EN maps the miss counter at MISS_ADDR.
package decap_rule_pkg;

   localparam logic [1:0] AXI_RESP_OK     = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
   typedef enum logic       {RD_IDLE, RD_RESP}          rd_state_t;
   typedef enum logic [2:0] {SEL_NONE, SEL_CTRL, SEL_CNT, SEL_GLOBAL, SEL_MISS} reg_sel_t;

   localparam logic [11:0] RULE_STRIDE = 12'h010;
   localparam logic [3:0]  CTRL_OFF    = 4'h0;
   localparam logic [3:0]  CNT_OFF     = 4'h4;
   localparam logic [11:0] GLOBAL_ADDR = 12'h100;
   localparam logic [11:0] MISS_ADDR   = 12'h104;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_MASK_LSB  = 8;
   localparam int CTRL_PROTO_LSB = 16;

   localparam logic [31:0] RULE0_RESET = 32'h00B2_0501;

   typedef struct packed {
      logic [7:0] proto;
      logic [7:0] mask;
      logic       en;
   } rule_ctrl_t;

   function automatic rule_ctrl_t ctrl_from_word(input logic [31:0] w);
      logic unused_w;
      unused_w             = ^{w[31:24], w[7:1]};
      ctrl_from_word.en    = w[CTRL_EN_BIT];
      ctrl_from_word.mask  = w[CTRL_MASK_LSB +: 8];
      ctrl_from_word.proto = w[CTRL_PROTO_LSB +: 8];
   endfunction

   function automatic logic [31:0] ctrl_to_word(input rule_ctrl_t c);
      ctrl_to_word                        = '0;
      ctrl_to_word[CTRL_EN_BIT]           = c.en;
      ctrl_to_word[CTRL_MASK_LSB +: 8]    = c.mask;
      ctrl_to_word[CTRL_PROTO_LSB +: 8]   = c.proto;
   endfunction

   // Rule registers occupy [0, RULE_STRIDE*nrules); only CTRL/CNT offsets exist.
   function automatic reg_sel_t decode_addr(input logic [11:0] a, input int unsigned nrules);
      decode_addr = SEL_NONE;
      if ({20'b0, a} < 32'(RULE_STRIDE) * nrules) begin
         if (a[3:0] == CTRL_OFF)     decode_addr = SEL_CTRL;
         else if (a[3:0] == CNT_OFF) decode_addr = SEL_CNT;
      end else if (a == GLOBAL_ADDR) begin
         decode_addr = SEL_GLOBAL;
      end
`ifdef DECAP_RULE_MISS_CNT_EN
      else if (a == MISS_ADDR) begin
         decode_addr = SEL_MISS;
      end
`endif
   endfunction

endpackage

// File: rtl/decap_rule_table_if.sv
// decap_rule_table_if: AXI4-Lite bus bundle for the decap rule table.
//   slave modport  : used by decap_rule_table.
//   master modport : used by the bus initiator.
interface decap_rule_table_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic                    AWVALID, AWREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WVALID, WREADY;
   logic [1:0]              BRESP;
   logic                    BVALID, BREADY;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic                    ARVALID, ARREADY;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;
   logic                    RVALID, RREADY;

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/decap_rule_match.sv
// decap_rule_match: combinational rule evaluation.
//   ctrl     : per-rule CTRL fields
//   glb_en   : global enable
//   src_port : 8-bit source port from tuser
//   hit/idx/proto : lowest-index hitting rule, or all zero on no hit
module decap_rule_match
   import decap_rule_pkg::*;
#(
   parameter int NUM_RULES = 4
) (
   input  rule_ctrl_t [NUM_RULES-1:0] ctrl,
   input  logic                       glb_en,
   input  logic [7:0]                 src_port,
   output logic                       hit,
   output logic [3:0]                 idx,
   output logic [7:0]                 proto
);
   logic [NUM_RULES-1:0] hit_vec;

   for (genvar g = 0; g < NUM_RULES; g++) begin : g_hit
      assign hit_vec[g] = glb_en & ctrl[g].en & (|(src_port & ctrl[g].mask));
   end

   // Scan high to low so the lowest hitting index is the last assignment.
   always_comb begin
      hit   = 1'b0;
      idx   = '0;
      proto = '0;
      for (int i = NUM_RULES - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            hit   = 1'b1;
            idx   = 4'(i);
            proto = ctrl[i].proto;
         end
      end
   end
endmodule

// File: rtl/decap_rule_table.sv
// decap_rule_table: NUM_RULES programmable decap rules behind AXI4-Lite.
//   ACLK/ARESETN   : clock, synchronous active-low reset
//   s_axis_*       : observed stream sideband/handshake (SOP detection, src port)
//   decap_begin, encap_proto, rule_idx : decision held for the whole packet
//   decision_valid : one-cycle pulse when a new decision loads
//   axi            : AXI4-Lite slave (rule CTRL/CNT, GLOBAL, optional MISS)
// Optional feature: DECAP_RULE_MISS_CNT_EN adds a saturating miss counter at 0x104.
module decap_rule_table
   import decap_rule_pkg::*;
#(
   parameter int DATA_WIDTH           = 32,
   parameter int ADDR_WIDTH           = 32,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int SRC_PORT_POS         = 16,
   parameter int NUM_RULES            = 4,
   parameter int CNT_WIDTH            = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic                            decap_begin,
   output logic [7:0]                      encap_proto,
   output logic [3:0]                      rule_idx,
   output logic                            decision_valid,
   decap_rule_table_if.slave               axi
);
   wr_state_t wr_state_q, wr_state_d;
   rd_state_t rd_state_q, rd_state_d;
   logic [11:0] waddr_q, waddr_d, raddr_q, raddr_d;
   logic [1:0]  bresp_q, bresp_d;
   rule_ctrl_t [NUM_RULES-1:0] ctrl_q, ctrl_d;
   logic glb_en_q, glb_en_d;
   logic [NUM_RULES-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef DECAP_RULE_MISS_CNT_EN
   logic [CNT_WIDTH-1:0] miss_q, miss_d;
`endif
   logic sop_pending_q, sop_pending_d;
   logic decap_q, decap_d, dvalid_q, dvalid_d;
   logic [7:0] proto_q, proto_d;
   logic [3:0] idx_q, idx_d;

   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        m_hit, beat, sop, wr_fire;
   logic [3:0]  m_idx;
   logic [7:0]  m_proto;
   reg_sel_t    wsel, rsel;

   logic unused_ok;
   assign unused_ok = ^{s_axis_tuser, axi.AWADDR[ADDR_WIDTH-1:12],
                        axi.ARADDR[ADDR_WIDTH-1:12], axi.WSTRB};

   decap_rule_match #(.NUM_RULES(NUM_RULES)) u_match (
      .ctrl     (ctrl_q),
      .glb_en   (glb_en_q),
      .src_port (s_axis_tuser[SRC_PORT_POS +: 8]),
      .hit      (m_hit),
      .idx      (m_idx),
      .proto    (m_proto)
   );

   assign beat    = s_axis_tvalid & s_axis_tready;
   assign sop     = beat & sop_pending_q;
   assign wsel    = decode_addr(waddr_q, NUM_RULES);
   assign rsel    = decode_addr(raddr_q, NUM_RULES);
   assign wr_fire = (wr_state_q == WR_DATA) & axi.WVALID;

   // Write channel, config registers and counters.
   always_comb begin
      wr_state_d = wr_state_q;
      waddr_d    = waddr_q;
      bresp_d    = bresp_q;
      ctrl_d     = ctrl_q;
      glb_en_d   = glb_en_q;
      cnt_d      = cnt_q;
      case (wr_state_q)
         WR_IDLE: if (axi.AWVALID) begin
            waddr_d    = axi.AWADDR[11:0];
            wr_state_d = WR_DATA;
         end
         WR_DATA: if (axi.WVALID) begin
            bresp_d    = (wsel == SEL_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OK;
            wr_state_d = WR_RESP;
         end
         WR_RESP: if (axi.BREADY) wr_state_d = WR_IDLE;
         default: wr_state_d = WR_IDLE;
      endcase
      if (wr_fire && wsel == SEL_GLOBAL) glb_en_d = axi.WDATA[0];
      for (int i = 0; i < NUM_RULES; i++) begin
         if (wr_fire && wsel == SEL_CTRL && waddr_q[7:4] == 4'(i))
            ctrl_d[i] = ctrl_from_word(axi.WDATA[31:0]);
         // Clear first, then increment: a coincident clear and hit yields 1.
         if (wr_fire && wsel == SEL_CNT && waddr_q[7:4] == 4'(i))
            cnt_d[i] = '0;
         if (sop && m_hit && m_idx == 4'(i) && cnt_d[i] != '1)
            cnt_d[i] = cnt_d[i] + 1'b1;
      end
   end

`ifdef DECAP_RULE_MISS_CNT_EN
   always_comb begin
      miss_d = miss_q;
      if (wr_fire && wsel == SEL_MISS) miss_d = '0;
      if (sop && !m_hit && miss_d != '1) miss_d = miss_d + 1'b1;
   end
`endif

   // Read channel; data decoded live from the latched address.
   always_comb begin
      rd_state_d = rd_state_q;
      raddr_d    = raddr_q;
      rdata      = '0;
      rresp      = AXI_RESP_OK;
      case (rd_state_q)
         RD_IDLE: if (axi.ARVALID) begin
            raddr_d    = axi.ARADDR[11:0];
            rd_state_d = RD_RESP;
         end
         RD_RESP: if (axi.RREADY) rd_state_d = RD_IDLE;
         default: rd_state_d = RD_IDLE;
      endcase
      case (rsel)
         SEL_CTRL: for (int i = 0; i < NUM_RULES; i++)
            if (raddr_q[7:4] == 4'(i)) rdata = ctrl_to_word(ctrl_q[i]);
         SEL_CNT: for (int i = 0; i < NUM_RULES; i++)
            if (raddr_q[7:4] == 4'(i)) rdata = 32'(cnt_q[i]);
         SEL_GLOBAL: rdata = {31'b0, glb_en_q};
`ifdef DECAP_RULE_MISS_CNT_EN
         SEL_MISS: rdata = 32'(miss_q);
`endif
         default: rresp = AXI_RESP_SLVERR;
      endcase
   end

   // Packet tracking and decision register.
   always_comb begin
      sop_pending_d = beat ? s_axis_tlast : sop_pending_q;
      decap_d       = decap_q;
      proto_d       = proto_q;
      idx_d         = idx_q;
      dvalid_d      = sop;
      if (sop) begin
         decap_d = m_hit;
         proto_d = m_proto;
         idx_d   = m_idx;
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wr_state_q    <= WR_IDLE;
         rd_state_q    <= RD_IDLE;
         waddr_q       <= '0;
         raddr_q       <= '0;
         bresp_q       <= AXI_RESP_OK;
         for (int i = 0; i < NUM_RULES; i++)
            ctrl_q[i]  <= (i == 0) ? ctrl_from_word(RULE0_RESET) : '0;
         glb_en_q      <= 1'b1;
         cnt_q         <= '0;
`ifdef DECAP_RULE_MISS_CNT_EN
         miss_q        <= '0;
`endif
         sop_pending_q <= 1'b1;
         decap_q       <= 1'b0;
         proto_q       <= '0;
         idx_q         <= '0;
         dvalid_q      <= 1'b0;
      end else begin
         wr_state_q    <= wr_state_d;
         rd_state_q    <= rd_state_d;
         waddr_q       <= waddr_d;
         raddr_q       <= raddr_d;
         bresp_q       <= bresp_d;
         ctrl_q        <= ctrl_d;
         glb_en_q      <= glb_en_d;
         cnt_q         <= cnt_d;
`ifdef DECAP_RULE_MISS_CNT_EN
         miss_q        <= miss_d;
`endif
         sop_pending_q <= sop_pending_d;
         decap_q       <= decap_d;
         proto_q       <= proto_d;
         idx_q         <= idx_d;
         dvalid_q      <= dvalid_d;
      end
   end

   assign decap_begin    = decap_q;
   assign encap_proto    = proto_q;
   assign rule_idx       = idx_q;
   assign decision_valid = dvalid_q;

   assign axi.AWREADY = (wr_state_q == WR_IDLE);
   assign axi.WREADY  = (wr_state_q == WR_DATA);
   assign axi.BVALID  = (wr_state_q == WR_RESP);
   assign axi.BRESP   = bresp_q;
   assign axi.ARREADY = (rd_state_q == RD_IDLE);
   assign axi.RVALID  = (rd_state_q == RD_RESP);
   assign axi.RDATA   = rdata;
   assign axi.RRESP   = rresp;
endmodule

// File: tb/tb_decap_rule_table.sv
// tb_decap_rule_table: randomized + directed bench for decap_rule_table with an
// in-bench behavioural model of the rule table, counters and packet decisions.
module tb_decap_rule_table;
   localparam int NR = 4;

   logic         ACLK = 1'b0;
   logic         ARESETN = 1'b0;
   logic [127:0] s_tuser = '0;
   logic         s_tvalid = 1'b0, s_tready = 1'b0, s_tlast = 1'b0;
   logic         decap_begin, decision_valid;
   logic [7:0]   encap_proto;
   logic [3:0]   rule_idx;

   int n_chk = 0;
   int n_fail = 0;

   decap_rule_table_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   decap_rule_table #(.NUM_RULES(NR)) dut (
      .ACLK           (ACLK),
      .ARESETN        (ARESETN),
      .s_axis_tuser   (s_tuser),
      .s_axis_tvalid  (s_tvalid),
      .s_axis_tready  (s_tready),
      .s_axis_tlast   (s_tlast),
      .decap_begin    (decap_begin),
      .encap_proto    (encap_proto),
      .rule_idx       (rule_idx),
      .decision_valid (decision_valid),
      .axi            (bus)
   );

   always #5 ACLK = ~ACLK;

   // ---------------- behavioural model ----------------
   logic [31:0] ctrl_m [NR];
   logic [31:0] cnt_m  [NR];
   logic [31:0] miss_m;
   logic        glb_m, sop_m, armed = 1'b0;
   logic [31:0] wa_m;
   logic        exp_decap, exp_dv;
   logic [7:0]  exp_proto;
   logic [3:0]  exp_idx;

   always @(posedge ACLK) begin
      int win;
      logic [11:0] a;
      logic [7:0]  src;
      armed = 1'b1;
      if (!ARESETN) begin
         for (int i = 0; i < NR; i++) begin
            ctrl_m[i] = (i == 0) ? 32'h00B20501 : 32'h0;
            cnt_m[i]  = 0;
         end
         miss_m = 0; glb_m = 1; sop_m = 1; wa_m = 0;
         exp_decap = 0; exp_proto = 0; exp_idx = 0; exp_dv = 0;
      end else begin
         win = -1;
         exp_dv = 0;
         if (s_tvalid && s_tready) begin
            if (sop_m) begin
               src = s_tuser[23:16];
               for (int i = NR - 1; i >= 0; i--)
                  if (glb_m && ctrl_m[i][0] && ((src & ctrl_m[i][15:8]) != 0)) win = i;
               exp_dv    = 1;
               exp_decap = (win >= 0);
               exp_proto = (win >= 0) ? ctrl_m[win][23:16] : 8'h0;
               exp_idx   = (win >= 0) ? 4'(win) : 4'h0;
            end
            sop_m = s_tlast;
         end
         a = wa_m[11:0];
         if (bus.WVALID && bus.WREADY) begin
            for (int i = 0; i < NR; i++) if (a == 12'(16 * i + 4)) cnt_m[i] = 0;
`ifdef DECAP_RULE_MISS_CNT_EN
            if (a == 12'h104) miss_m = 0;
`endif
         end
         if (exp_dv && win >= 0 && cnt_m[win] != 32'hFFFFFFFF) cnt_m[win]++;
         if (exp_dv && win < 0 && miss_m != 32'hFFFFFFFF) miss_m++;
         if (bus.WVALID && bus.WREADY) begin
            for (int i = 0; i < NR; i++)
               if (a == 12'(16 * i)) ctrl_m[i] = bus.WDATA & 32'h00FFFF01;
            if (a == 12'h100) glb_m = bus.WDATA[0];
         end
         if (bus.AWVALID && bus.AWREADY) wa_m = bus.AWADDR;
      end
   end

   function automatic void mread(input logic [31:0] addr, output logic [31:0] d,
                                 output logic [1:0] r);
      logic [11:0] a = addr[11:0];
      d = 0; r = 2'b10;
      for (int i = 0; i < NR; i++) begin
         if (a == 12'(16 * i))     begin d = ctrl_m[i]; r = 0; end
         if (a == 12'(16 * i + 4)) begin d = cnt_m[i];  r = 0; end
      end
      if (a == 12'h100) begin d = {31'b0, glb_m}; r = 0; end
`ifdef DECAP_RULE_MISS_CNT_EN
      if (a == 12'h104) begin d = miss_m; r = 0; end
`endif
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tmo(input string nm);
      n_chk++; n_fail++;
      $display("FAIL timeout %s at %0t", nm, $time);
   endtask

   always @(negedge ACLK) begin
      if (armed) begin
         chk("decap_begin", {31'b0, decap_begin}, {31'b0, exp_decap});
         chk("encap_proto", {24'b0, encap_proto}, {24'b0, exp_proto});
         chk("rule_idx", {28'b0, rule_idx}, {28'b0, exp_idx});
         chk("decision_valid", {31'b0, decision_valid}, {31'b0, exp_dv});
      end
   end

   // ---------------- bus / stream drivers ----------------
   task automatic axi_aw(input logic [31:0] a);
      int n = 0;
      bus.AWADDR = a; bus.AWVALID = 1;
      while (!bus.AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
      if (n >= 50) tmo("awready");
      @(posedge ACLK); #1; bus.AWVALID = 0;
   endtask

   task automatic axi_b(output logic [1:0] r);
      int n = 0;
      bus.BREADY = 1;
      while (!bus.BVALID && n < 50) begin @(posedge ACLK); #1; n++; end
      if (n >= 50) tmo("bvalid");
      r = bus.BRESP;
      @(posedge ACLK); #1; bus.BREADY = 0;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] r);
      int n = 0;
      axi_aw(a);
      bus.WDATA = d; bus.WSTRB = 4'hF; bus.WVALID = 1;
      while (!bus.WREADY && n < 50) begin @(posedge ACLK); #1; n++; end
      if (n >= 50) tmo("wready");
      @(posedge ACLK); #1; bus.WVALID = 0;
      axi_b(r);
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      int n = 0;
      bus.ARADDR = a; bus.ARVALID = 1;
      while (!bus.ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
      if (n >= 50) tmo("arready");
      @(posedge ACLK); #1; bus.ARVALID = 0; bus.RREADY = 1;
      n = 0;
      while (!bus.RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
      if (n >= 50) tmo("rvalid");
      d = bus.RDATA; r = bus.RRESP;
      @(posedge ACLK); #1; bus.RREADY = 0;
   endtask

   task automatic read_vs_model(input logic [31:0] a);
      logic [31:0] d, ed;
      logic [1:0]  r, er;
      axi_read(a, d, r);
      mread(a, ed, er);
      chk($sformatf("rdata@%0h", a), d, ed);
      chk($sformatf("rresp@%0h", a), {30'b0, r}, {30'b0, er});
   endtask

   task automatic beat(input logic [7:0] src, input logic last);
      s_tuser = {$urandom, $urandom, $urandom, $urandom};
      s_tuser[23:16] = src;
      s_tvalid = 1; s_tready = 1; s_tlast = last;
      @(posedge ACLK); #1;
      s_tvalid = 0; s_tlast = 0;
   endtask

   task automatic outs(input string nm, input logic d, input logic [7:0] p, input logic [3:0] ix);
      chk({nm, ".decap"}, {31'b0, decap_begin}, {31'b0, d});
      chk({nm, ".proto"}, {24'b0, encap_proto}, {24'b0, p});
      chk({nm, ".idx"}, {28'b0, rule_idx}, {28'b0, ix});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      bus.AWADDR = 0; bus.AWVALID = 0; bus.WDATA = 0; bus.WSTRB = 0; bus.WVALID = 0;
      bus.BREADY = 0; bus.ARADDR = 0; bus.ARVALID = 0; bus.RREADY = 0;
      repeat (3) @(posedge ACLK);
      #1 ARESETN = 1;
      @(posedge ACLK); #1;
      outs("reset", 0, 8'h00, 4'h0);
      axi_read(32'h000, d, r); chk("rst_ctrl0", d, 32'h00B20501);
      axi_read(32'h100, d, r); chk("rst_global", d, 32'h1);

      // rule0 default hit
      beat(8'h01, 1);
      outs("t1", 1, 8'hB2, 4'h0);
      chk("t1.dv", {31'b0, decision_valid}, 32'h1);
      axi_read(32'h004, d, r); chk("t1.cnt0", d, 32'h1);

      // rule1 hit with rule0 disabled; then no hit
      axi_write(32'h010, 32'h00330201, r);
      axi_write(32'h000, 32'h00B20500, r);
      beat(8'h02, 1);
      outs("t2", 1, 8'h33, 4'h1);
      beat(8'h04, 1);
      outs("t2miss", 0, 8'h00, 4'h0);

      // priority: rule0 mask 05 beats rule2 mask 04
      axi_write(32'h000, 32'h00B20501, r);
      axi_write(32'h020, 32'h00440401, r);
      beat(8'h04, 1);
      outs("t3", 1, 8'hB2, 4'h0);

      // mid-packet config change holds decision
      beat(8'h01, 0);
      axi_write(32'h100, 32'h0, r);
      outs("t4mid", 1, 8'hB2, 4'h0);
      beat(8'h01, 0); beat(8'h01, 0); beat(8'h01, 1);
      outs("t4end", 1, 8'hB2, 4'h0);
      beat(8'h01, 1);
      outs("t4next", 0, 8'h00, 4'h0);
      axi_write(32'h100, 32'h1, r);

      // unmapped access
      axi_read(32'h0F0, d, r);
      chk("unmap.rdata", d, 32'h0);
      chk("unmap.rresp", {30'b0, r}, 32'h2);
      axi_write(32'h0F0, 32'hFFFFFFFF, r);
      chk("unmap.bresp", {30'b0, r}, 32'h2);

      // CNT0 clear coincident with a rule0 increment
      axi_aw(32'h004);
      bus.WDATA = 0; bus.WSTRB = 4'hF; bus.WVALID = 1;
      s_tuser = '0; s_tuser[23:16] = 8'h01; s_tvalid = 1; s_tready = 1; s_tlast = 1;
      @(posedge ACLK); #1;
      bus.WVALID = 0; s_tvalid = 0; s_tlast = 0;
      axi_b(r);
      axi_read(32'h004, d, r); chk("clr_inc.cnt0", d, 32'h1);

      // reset mid-packet
      beat(8'h02, 0);
      ARESETN = 0;
      repeat (2) @(posedge ACLK);
      #1 ARESETN = 1;
      outs("rst_mid", 0, 8'h00, 4'h0);
      axi_read(32'h004, d, r); chk("rst_mid.cnt0", d, 32'h0);
      beat(8'h01, 1);
      outs("rst_sop", 1, 8'hB2, 4'h0);

      // miss counter
`ifdef DECAP_RULE_MISS_CNT_EN
      axi_write(32'h104, 32'h0, r);
      repeat (3) beat(8'h80, 1);
      axi_read(32'h104, d, r); chk("miss3", d, 32'h3);
`else
      axi_read(32'h104, d, r); chk("miss_unmapped", {30'b0, r}, 32'h2);
`endif

      // randomized traffic and config
      for (int it = 0; it < 300; it++) begin
         int k = $urandom_range(0, 9);
         if (k < 2) begin
            logic [31:0] a = 32'(16 * $urandom_range(0, NR - 1));
            if ($urandom_range(0, 3) == 0) a = 32'h100;
            else if ($urandom_range(0, 5) == 0) a = a + 4;
            axi_write(a, $urandom, r);
         end else begin
            int nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
               while ($urandom_range(0, 3) == 0) begin
                  s_tvalid = $urandom_range(0, 1); s_tready = ~s_tvalid; s_tlast = 1;
                  @(posedge ACLK); #1;
                  s_tvalid = 0; s_tlast = 0;
               end
               beat(8'(1 << $urandom_range(0, 7)) | ($urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h0),
                    b == nb - 1);
            end
         end
      end
      s_tready = 0;
      repeat (2) @(posedge ACLK); #1;
      for (int i = 0; i < NR; i++) begin
         read_vs_model(32'(16 * i));
         read_vs_model(32'(16 * i + 4));
      end
      read_vs_model(32'h100);
      read_vs_model(32'h104);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
